// File: rtl/ls161_compare_counter.sv
// Chained 74LS161-style loadable counter with registered magnitude compare and an arm/match FSM.
// Optional macro CASCADE_IN_EN adds GTI/EQI/LTI cascade inputs from a less-significant comparator.
module ls161_compare_counter #(
  parameter int NIBBLES = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   LOAD,
  input  logic                   ENP,
  input  logic                   ENT,
  input  logic [4*NIBBLES-1:0]   D,
  input  logic [4*NIBBLES-1:0]   CMPV,
  input  logic                   ARM,
`ifdef CASCADE_IN_EN
  input  logic                   GTI,
  input  logic                   EQI,
  input  logic                   LTI,
`endif
  output logic [4*NIBBLES-1:0]   Q,
  output logic                   RCO,
  output logic                   AgtB,
  output logic                   AeqB,
  output logic                   AltB,
  output logic                   MATCH,
  output logic                   HIT
);

  localparam int W = 4 * NIBBLES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HIT
  } state_t;

  logic [W-1:0] q_q, q_d;
  logic         gt_q, gt_d;
  logic         eq_q, eq_d;
  logic         lt_q, lt_d;
  logic         match_q, match_d;
  state_t       state_q, state_d;
  logic         carry;

  // Per-nibble carry chain: stage k counts only when every lower nibble is 0xF.
  always_comb begin
    q_d   = q_q;
    carry = ENP & ENT;
    if (LOAD) begin
      q_d = D;
    end else begin
      for (int unsigned k = 0; k < NIBBLES; k++) begin
        if (carry) q_d[4*k +: 4] = q_q[4*k +: 4] + 4'd1;
        carry = carry & (q_q[4*k +: 4] == 4'hF);
      end
    end
  end

  always_comb begin
`ifdef CASCADE_IN_EN
    gt_d = (q_q > CMPV) | ((q_q == CMPV) & ~EQI & GTI);
    eq_d = (q_q == CMPV) & EQI;
    lt_d = (q_q < CMPV) | ((q_q == CMPV) & ~EQI & LTI);
`else
    gt_d = (q_q > CMPV);
    eq_d = (q_q == CMPV);
    lt_d = (q_q < CMPV);
`endif
  end

  // FSM reacts to the registered equality flag, so MATCH lands two edges after Q==CMPV.
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (ARM) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!ARM) begin
          state_d = ST_IDLE;
        end else if (eq_q) begin
          state_d = ST_HIT;
          match_d = 1'b1;
        end
      end
      ST_HIT:   if (!ARM) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q     <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      match_q <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      q_q     <= q_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      match_q <= match_d;
      state_q <= state_d;
    end
  end

  assign Q     = q_q;
  assign RCO   = ENT & (&q_q);
  assign AgtB  = gt_q;
  assign AeqB  = eq_q;
  assign AltB  = lt_q;
  assign MATCH = match_q;
  assign HIT   = (state_q == ST_HIT);

endmodule

// File: tb/tb_ls161_compare_counter.sv
// Directed bench for ls161_compare_counter: arithmetic reference model checked every cycle plus literal checkpoints.
module tb_ls161_compare_counter;

  localparam int NIB = 2;
  localparam int W = 4 * NIB;
  localparam int unsigned MAXV = (32'd1 << W) - 1;

  logic         CLK, RST, LOAD, ENP, ENT, ARM;
  logic [W-1:0] D, CMPV, Q;
  logic         RCO, AgtB, AeqB, AltB, MATCH, HIT;
`ifdef CASCADE_IN_EN
  logic         GTI, EQI, LTI;
`endif

  ls161_compare_counter #(.NIBBLES(NIB)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .ENP(ENP), .ENT(ENT),
    .D(D), .CMPV(CMPV), .ARM(ARM),
`ifdef CASCADE_IN_EN
    .GTI(GTI), .EQI(EQI), .LTI(LTI),
`endif
    .Q(Q), .RCO(RCO), .AgtB(AgtB), .AeqB(AeqB), .AltB(AltB),
    .MATCH(MATCH), .HIT(HIT)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer counter, compare of the value held before each edge,
  // and a two-flag view of the arm/hit behaviour.
  int unsigned q_m;
  bit gt_m, eq_m, lt_m, match_m, hit_m, armed_m, eq_prev;
  bit eqi_v, gti_v, lti_v;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_m = 0; gt_m = 0; eq_m = 0; lt_m = 0;
      match_m = 0; hit_m = 0; armed_m = 0;
    end else begin
`ifdef CASCADE_IN_EN
      eqi_v = EQI; gti_v = GTI; lti_v = LTI;
`else
      eqi_v = 1; gti_v = 0; lti_v = 0;
`endif
      eq_prev = eq_m;
      match_m = 0;
      if (hit_m) begin
        if (!ARM) hit_m = 0;
      end else if (armed_m) begin
        if (!ARM) armed_m = 0;
        else if (eq_prev) begin
          armed_m = 0; hit_m = 1; match_m = 1;
        end
      end else if (ARM) begin
        armed_m = 1;
      end
      gt_m = (q_m > CMPV) || (q_m == CMPV && !eqi_v && gti_v);
      eq_m = (q_m == CMPV) && eqi_v;
      lt_m = (q_m < CMPV) || (q_m == CMPV && !eqi_v && lti_v);
      if (LOAD) q_m = D;
      else if (ENP && ENT) q_m = (q_m + 1) & MAXV;
    end
  end

  always @(negedge CLK) begin
    if (chk_en && !RST) begin
      chk("q", Q, q_m);
      chk("rco", RCO, (ENT && q_m == MAXV) ? 1 : 0);
      chk("agtb", AgtB, gt_m);
      chk("aeqb", AeqB, eq_m);
      chk("altb", AltB, lt_m);
      chk("match", MATCH, match_m);
      chk("hit", HIT, hit_m);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl, input logic [31:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  int npulse;
  int unsigned q_at_pulse;
  bit ok;

  initial begin
    RST = 1; LOAD = 0; ENP = 0; ENT = 0; ARM = 0; D = '0; CMPV = '0;
`ifdef CASCADE_IN_EN
    GTI = 0; EQI = 1; LTI = 0;
`endif
    #2;
    lit("rst_q", Q, q_m, 0);
    chk("rst_flags", {AgtB, AeqB, AltB, MATCH, HIT}, 5'b0);
    #10 RST = 0;  // t=12, between edges
    #1;
    chk("pre_edge_flags", {AgtB, AeqB, AltB}, 3'b000);
    chk_en = 1;
    ENP = 1; ENT = 1;
    step(5);
    lit("count5", Q, q_m, 8'h05);

    // Wrap and RCO
    LOAD = 1; D = 8'hFE; step(1); LOAD = 0;
    lit("load_fe", Q, q_m, 8'hFE);
    step(1);
    lit("q_ff", Q, q_m, 8'hFF);
    chk("rco_ff", RCO, 1);
    step(1);
    lit("wrap0", Q, q_m, 8'h00);
    chk("rco_wrap", RCO, 0);
    ENT = 0; LOAD = 1; D = 8'hFF; step(1); LOAD = 0;
    chk("rco_ent0", RCO, 0);
    step(1);
    lit("hold_ent0", Q, q_m, 8'hFF);

    // Load priority and ENP hold
    ENP = 1; ENT = 1; LOAD = 1; D = 8'h3C; step(1);
    lit("load_prio", Q, q_m, 8'h3C);
    LOAD = 0; ENP = 0; step(1);
    lit("hold_enp0", Q, q_m, 8'h3C);

    // Compare latency around CMPV=0x10
    CMPV = 8'h10; LOAD = 1; D = 8'h0E; step(1); LOAD = 0; ENP = 1;
    step(1);
    lit("q_0f", Q, q_m, 8'h0F);
    chk("lt_at_0f", {AgtB, AeqB, AltB}, 3'b001);
    step(1);
    chk("lt_at_10", {AgtB, AeqB, AltB}, 3'b001);
    step(1);
    chk("eq_at_11", {AgtB, AeqB, AltB}, 3'b010);
    step(1);
    chk("gt_at_12", {AgtB, AeqB, AltB}, 3'b100);

    // Match FSM: single pulse, HIT holds through wrap
    CMPV = 8'h08; ARM = 1; LOAD = 1; D = 8'h00; step(1); LOAD = 0;
    npulse = 0; q_at_pulse = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (MATCH) begin
        npulse++;
        q_at_pulse = Q;
      end
    end
    chk("match_count", npulse, 1);
    chk("match_q", q_at_pulse, 8'h0A);
    chk("hit_held", HIT, 1);
    ARM = 0; step(1);
    lit("hit_drop", HIT, hit_m, 0);

    // ARM dropped in the AeqB cycle
    ARM = 1; LOAD = 1; D = 8'h00; step(1); LOAD = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (AeqB) begin ok = 1; break; end
      step(1);
    end
    chk("aeq_wait", ok, 1);
    ARM = 0; step(1);
    chk("no_match_abort", {MATCH, HIT}, 2'b00);

    // Async reset while HIT with Q=0x08
    ARM = 1; LOAD = 1; D = 8'h00; step(1); LOAD = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (HIT) begin ok = 1; break; end
      step(1);
    end
    chk("hit_wait", ok, 1);
    ENP = 0; LOAD = 1; D = 8'h08; step(1); LOAD = 0;
    lit("q_08_hit", {Q, HIT}, {q_m[7:0], hit_m}, {8'h08, 1'b1});
    #2 RST = 1;
    #1;
    lit("arst_q", Q, q_m, 0);
    chk("arst_state", {AgtB, AeqB, AltB, MATCH, HIT}, 5'b0);
    #2 RST = 0;
    step(4);
    chk("rearm_hit", HIT, hit_m);

`ifdef CASCADE_IN_EN
    ARM = 0; LOAD = 1; D = 8'h55; CMPV = 8'h55; step(1); LOAD = 0;
    EQI = 0; GTI = 1; LTI = 0; step(2);
    chk("casc_flags", {AgtB, AeqB, AltB}, 3'b100);
`endif

    step(2);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
